// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared FSM encoding, Q1.15 widths and default taps for the FIR scheduler
package fir_sched_pkg;

  localparam int Q_COEFF_WIDTH    = 16;
  localparam int Q_FRACTION_WIDTH = 15;
  localparam int NUM_TAPS         = 4;

  localparam logic [15:0] H0_DEFAULT = 16'h1000;
  localparam logic [15:0] H1_DEFAULT = 16'h2000;
  localparam logic [15:0] H2_DEFAULT = 16'h2000;
  localparam logic [15:0] H3_DEFAULT = 16'h1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_MAC    = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/fir_mac_scheduler_rr_arbiter.sv
// rtl/fir_mac_scheduler_rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr+1
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx
);

  logic            w_found;
  logic [CH_W-1:0] w_cand;

  // First requester after the last-served channel wins; wraps modulo NUM_CH
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = CH_W'((int'(i_ptr) + i) % NUM_CH);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - multi-channel 4-tap FIR sharing one multiplier under round-robin scheduling
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH               = 2,
  parameter int CH_W                 = 1,
  parameter int DATA_WIDTH           = 16,
  parameter int COEFF_WIDTH          = Q_COEFF_WIDTH,
  parameter int COEFF_FRACTION_WIDTH = Q_FRACTION_WIDTH,
  parameter int ACC_WIDTH            = DATA_WIDTH + COEFF_WIDTH - COEFF_FRACTION_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]            i_valid,
  output logic [NUM_CH-1:0]            o_ready,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_addr,
  input  logic [COEFF_WIDTH-1:0]       cfg_data,
  output logic                         o_cfg_ready,
  output logic [ACC_WIDTH-1:0]         o_data_sum,
  output logic [CH_W-1:0]              o_ch,
  output logic                         o_data_valid
);

  state_t r_state, w_state_next;

  logic [NUM_CH-1:0]                   r_pend;
  logic [NUM_CH-1:0]                   r_gnt_oh;
  logic [CH_W-1:0]                     r_ch;
  logic [CH_W-1:0]                     r_ptr;
  logic [1:0]                          r_k;
  logic signed [ACC_WIDTH-1:0]         r_acc;
  logic [ACC_WIDTH-1:0]                r_sum;
  logic signed [DATA_WIDTH-1:0]        r_hold [NUM_CH];
  logic signed [DATA_WIDTH-1:0]        r_x    [NUM_CH][NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]       r_h    [NUM_TAPS];

  logic [NUM_CH-1:0]                   w_accept;
  logic [NUM_CH-1:0]                   w_clr;
  logic [NUM_CH-1:0]                   w_gnt;
  logic [CH_W-1:0]                     w_gnt_idx;
  logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]         w_pk;
  logic signed [ACC_WIDTH-1:0]         w_acc_next;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  assign w_accept     = i_valid & ~r_pend;
  assign w_clr        = (r_state == ST_LOAD) ? r_gnt_oh : '0;
  assign w_prod       = r_x[r_ch][r_k] * r_h[r_k];
  assign w_pk         = ACC_WIDTH'(w_prod >>> COEFF_FRACTION_WIDTH);
  assign w_acc_next   = (r_k == 2'd0) ? w_pk : (r_acc + w_pk);

  assign o_ready      = ~r_pend;
  assign o_cfg_ready  = (r_state == ST_IDLE);
  assign o_data_valid = (r_state == ST_OUTPUT);
  assign o_data_sum   = r_sum;
  assign o_ch         = r_ch;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Pass sequencing: IDLE -> LOAD -> MAC x4 -> OUTPUT -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (|r_pend) w_state_next = ST_LOAD;
      ST_LOAD:   w_state_next = ST_MAC;
      ST_MAC:    if (r_k == 2'd3) w_state_next = ST_OUTPUT;
      ST_OUTPUT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Sample acceptance and per-channel pending flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      for (int c = 0; c < NUM_CH; c++) r_hold[c] <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_accept;
      for (int c = 0; c < NUM_CH; c++)
        if (w_accept[c]) r_hold[c] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Coefficient bank; writes only land while idle so a pass never sees a torn tap set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h[0] <= COEFF_WIDTH'(H0_DEFAULT);
      r_h[1] <= COEFF_WIDTH'(H1_DEFAULT);
      r_h[2] <= COEFF_WIDTH'(H2_DEFAULT);
      r_h[3] <= COEFF_WIDTH'(H3_DEFAULT);
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_h[cfg_addr] <= cfg_data;
    end
  end

  // Grant capture, delay-line shift and shared multiply-accumulate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch     <= '0;
      r_ptr    <= CH_W'(NUM_CH - 1);
      r_gnt_oh <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < NUM_TAPS; t++) r_x[c][t] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pend) begin
            r_ch     <= w_gnt_idx;
            r_ptr    <= w_gnt_idx;
            r_gnt_oh <= w_gnt;
          end
        end
        ST_LOAD: begin
          r_x[r_ch][3] <= r_x[r_ch][2];
          r_x[r_ch][2] <= r_x[r_ch][1];
          r_x[r_ch][1] <= r_x[r_ch][0];
          r_x[r_ch][0] <= r_hold[r_ch];
          r_k          <= 2'd0;
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) r_sum <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - directed self-checking bench for fir_mac_scheduler
module tb_fir_mac_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] i_data = '0;
  logic [1:0]  i_valid = '0;
  logic [1:0]  o_ready;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        o_cfg_ready;
  logic [18:0] o_data_sum;
  logic [0:0]  o_ch;
  logic        o_data_valid;

  fir_mac_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .o_cfg_ready  (o_cfg_ready),
    .o_data_sum   (o_data_sum),
    .o_ch         (o_ch),
    .o_data_valid (o_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int ch;
    int smp;
    int exp_sum;
  } vec_t;

  vec_t vt [8];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat, lat2, held, outs, cyc, exp_ch, seen;
  int   nd   [2];
  int   line [2][4];
  int   q0[$];
  int   q1[$];
  logic [1:0] acc;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  function automatic int sum_out();
    return int'($signed(o_data_sum));
  endfunction

  function automatic int fir_model(input int x0, input int x1, input int x2, input int x3);
    longint s;
    s = ((longint'(x0) * 4096) >>> 15) + ((longint'(x1) * 8192) >>> 15)
      + ((longint'(x2) * 8192) >>> 15) + ((longint'(x3) * 4096) >>> 15);
    return int'(s);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_valid = '0;
    cfg_we  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input int c, input int v);
    int t;
    logic [15:0] s;
    t = 0;
    while (!o_ready[c] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    s = v[15:0];
    i_data[c*16 +: 16] = s;
    i_valid[c] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid[c] = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (!o_data_valid && l < 40) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    if (!o_data_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = a[1:0];
    cfg_data = d[15:0];
    @(posedge clk);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic handle_output();
    int c, x;
    c = int'(o_ch);
    chk("rr_grant_order", c, exp_ch);
    exp_ch = 1 - exp_ch;
    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
      chk("stream_unexpected_output", 0, 1);
    end else begin
      x = (c == 0) ? q0.pop_front() : q1.pop_front();
      line[c][3] = line[c][2];
      line[c][2] = line[c][1];
      line[c][1] = line[c][0];
      line[c][0] = x;
      chk("stream_sum", sum_out(), fir_model(line[c][0], line[c][1], line[c][2], line[c][3]));
    end
    outs++;
  endtask

  initial begin
    vt[0] = '{1, 0,  1000,  125};
    vt[1] = '{0, 0,  1000,  375};
    vt[2] = '{0, 0,  1000,  625};
    vt[3] = '{0, 0,  1000,  750};
    vt[4] = '{0, 0,  1000,  750};
    vt[5] = '{1, 0, -1000, -125};
    vt[6] = '{0, 0, 32767, 3845};
    vt[7] = '{0, 1,  2000,  250};

    do_reset();
    chk("reset_ready", int'(o_ready), 3);
    chk("reset_cfg_ready", int'(o_cfg_ready), 1);
    chk("reset_valid", int'(o_data_valid), 0);
    chk("reset_sum", sum_out(), 0);
    chk("reset_ch", int'(o_ch), 0);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].rst) do_reset();
      send(vt[i].ch, vt[i].smp);
      wait_result(lat);
      chk("vec_latency", lat, 6);
      chk("vec_sum", sum_out(), vt[i].exp_sum);
      chk("vec_ch", int'(o_ch), vt[i].ch);
      held = sum_out();
      @(posedge clk);
      @(negedge clk);
      chk("vec_valid_single", int'(o_data_valid), 0);
      chk("vec_sum_held", sum_out(), held);
    end

    do_reset();
    i_data  = {16'd2000, 16'd1000};
    i_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    i_valid = 2'b00;
    wait_result(lat);
    chk("dual_first_latency", lat, 6);
    chk("dual_first_sum", sum_out(), 125);
    chk("dual_first_ch", int'(o_ch), 0);
    chk("dual_ch1_still_pending", int'(o_ready[1]), 0);
    @(posedge clk);
    @(negedge clk);
    wait_result(lat2);
    chk("dual_spacing", lat2 + 1, 7);
    chk("dual_second_sum", sum_out(), 250);
    chk("dual_second_ch", int'(o_ch), 1);

    do_reset();
    chk("cfg_ready_idle", int'(o_cfg_ready), 1);
    cfg_write(0, 16'h4000);
    send(1, 1000);
    wait_result(lat);
    chk("cfg_h0_sum", sum_out(), 500);
    send(1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cfg_ready_busy", int'(o_cfg_ready), 0);
    cfg_write(0, 0);
    wait_result(lat);
    chk("cfg_busy_pass_sum", sum_out(), 250);
    send(0, 1000);
    wait_result(lat);
    chk("cfg_drop_kept_h0", sum_out(), 500);

    do_reset();
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < 4; t++) line[c][t] = 0;
    q0.delete();
    q1.delete();
    nd[0]  = 100;
    nd[1]  = -50;
    i_data = {nd[1][15:0], nd[0][15:0]};
    i_valid = 2'b11;
    outs   = 0;
    cyc    = 0;
    exp_ch = 0;
    while (outs < 20 && cyc < 600) begin
      if (o_data_valid) handle_output();
      acc = o_ready & i_valid;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (acc[c]) begin
          if (c == 0) q0.push_back(nd[0]);
          else        q1.push_back(nd[1]);
          chk("stream_ready_low", int'(o_ready[c]), 0);
          nd[c] = (c == 0) ? nd[c] + 100 : nd[c] - 50;
          i_data[c*16 +: 16] = nd[c][15:0];
        end
      end
    end
    chk("stream_output_count", outs, 20);
    i_valid = 2'b00;
    cyc = 0;
    while ((q0.size() + q1.size()) > 0 && cyc < 100) begin
      if (o_data_valid) handle_output();
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("stream_drained", q0.size() + q1.size(), 0);

    do_reset();
    send(0, 3000);
    wait_result(lat);
    chk("abort_pre_sum", sum_out(), 375);
    @(posedge clk);
    @(negedge clk);
    cfg_write(0, 16'h4000);
    send(0, 1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", int'(o_data_valid), 0);
    chk("abort_ready", int'(o_ready), 3);
    chk("abort_cfg_ready", int'(o_cfg_ready), 1);
    chk("abort_sum", sum_out(), 0);
    chk("abort_ch", int'(o_ch), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_data_valid) seen++;
    end
    chk("abort_no_strobe", seen, 0);
    send(0, 1000);
    wait_result(lat);
    chk("abort_post_latency", lat, 6);
    chk("abort_post_sum", sum_out(), 125);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
